// File: rtl/snn_pkg.sv
// Shared types and arithmetic helpers for the spiking layer engine.
// Helpers work on 32/64-bit containers with an explicit field width so any parameterisation can use them.
package snn_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_UPDATE,
    S_NEXT,
    S_FIN
  } state_t;

  function automatic logic [31:0] get_field(input logic [63:0] vec, input int idx, input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    return 32'((vec >> (idx * w)) & m);
  endfunction

  function automatic logic [63:0] put_field(input logic [63:0] vec, input int idx, input int w,
                                            input logic [31:0] val);
    logic [63:0] m;
    m = ((64'd1 << w) - 64'd1) << (idx * w);
    return (vec & ~m) | (({32'd0, val} << (idx * w)) & m);
  endfunction

  function automatic int sext(input logic [31:0] v, input int w);
    return $signed(v << (32 - w)) >>> (32 - w);
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int acc_w);
    logic [32:0] s;
    logic [32:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << acc_w) - 33'd1;
    return (s > lim) ? 32'(lim) : 32'(s);
  endfunction

  // Exponent shift: positive w multiplies (saturating), negative w divides; |w| >= acc_w gives 0.
  function automatic logic [31:0] sh(input logic [31:0] x, input int w, input int acc_w);
    logic [63:0] wide;
    logic [63:0] lim;
    lim = (64'd1 << acc_w) - 64'd1;
    if (w >= acc_w || -w >= acc_w) return 32'd0;
    if (w >= 0) begin
      wide = {32'd0, x} << w;
      return (wide > lim) ? 32'(lim) : 32'(wide);
    end
    return x >> (-w);
  endfunction

  function automatic int w_step(input int w, input logic up, input int w_w);
    int hi;
    int lo;
    hi = (1 << (w_w - 1)) - 1;
    lo = -(1 << (w_w - 1));
    if (up) return (w >= hi) ? hi : w + 1;
    return (w <= lo) ? lo : w - 1;
  endfunction

endpackage

// File: rtl/snn_neuron.sv
// One neuron: shift-weighted saturating sum, threshold spike and the saturating weight update of its row.
module snn_neuron
  import snn_pkg::*;
#(
  parameter int N_CH   = 2,
  parameter int W_W    = 4,
  parameter int ACC_W  = 8,
  parameter int THRESH = 1
) (
  input  logic [N_CH*ACC_W-1:0] x_i,
  input  logic [N_CH*W_W-1:0]   row_i,
  output logic [ACC_W-1:0]      acc_o,
  output logic                  spike_o,
  output logic [N_CH*W_W-1:0]   row_o
);

  logic [ACC_W-1:0] sum;
  logic [63:0]      row_acc;
  int               w;
  logic             pre;

  // NOTE: always_comb uses blocking assignments so the running sum is visible to the next iteration.
  always_comb begin
    sum = '0;
    for (int j = 0; j < N_CH; j++) begin
      sum = ACC_W'(sat_add(32'(sum),
                           sh(get_field(64'(x_i), j, ACC_W), sext(get_field(64'(row_i), j, W_W), W_W), ACC_W),
                           ACC_W));
    end
  end

  assign acc_o   = sum;
  assign spike_o = 32'(sum) > 32'(THRESH);

  // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    row_acc = '0;
    w       = 0;
    pre     = 1'b0;
    for (int j = 0; j < N_CH; j++) begin
      w   = sext(get_field(64'(row_i), j, W_W), W_W);
      pre = get_field(64'(x_i), j, ACC_W) > 32'(THRESH);
      if (pre) w = w_step(w, spike_o, W_W);
      row_acc = put_field(row_acc, j, W_W, 32'(w));
    end
  end

  assign row_o = (N_CH*W_W)'(row_acc);

endmodule

// File: rtl/snn_layer_engine.sv
// Multi-layer spiking network engine: fetches weight rows per layer, evaluates spikes,
// optionally writes back updated rows, and publishes last-layer activations with their argmax.
module snn_layer_engine
  import snn_pkg::*;
#(
  parameter int N_CH   = 2,
  parameter int W_W    = 4,
  parameter int ACC_W  = 8,
  parameter int LAYERS = 8,
  parameter int THRESH = 1,
  parameter int AW     = $clog2(LAYERS * N_CH),
  localparam int IW    = $clog2(N_CH),
  localparam int LW    = (LAYERS > 1) ? $clog2(LAYERS) : 1,
  localparam int CW    = $clog2(N_CH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  learn_en,
  input  logic                  hold,
  input  logic [N_CH*ACC_W-1:0] in_data,
  output logic                  busy,
  output logic                  done,
  output logic [AW-1:0]         mem_addr,
  output logic                  mem_rd_en,
  input  logic [N_CH*W_W-1:0]   mem_rdata,
  output logic                  mem_wr_en,
  output logic [N_CH*W_W-1:0]   mem_wdata,
  output logic [N_CH*ACC_W-1:0] pred,
  output logic [IW-1:0]         pred_idx
);

  state_t                          state_q;
  logic [LW-1:0]                   layer_q;
  logic [CW-1:0]                   cnt_q;
  logic                            learn_q;
  logic                            busy_q, done_q, rd_q, wr_q;
  logic [AW-1:0]                   addr_q;
  logic [N_CH*W_W-1:0]             wdata_q;
  logic [N_CH*ACC_W-1:0]           x_q, x_d, pred_q;
  logic [IW-1:0]                   idx_q, idx_d;
  logic [N_CH-1:0][N_CH*W_W-1:0]   rows_q, rows_d;
  logic [N_CH-1:0][ACC_W-1:0]      acc;
  logic [N_CH-1:0]                 spike;
  logic [ACC_W-1:0]                best;

  for (genvar i = 0; i < N_CH; i++) begin : g_neuron
    snn_neuron #(
      .N_CH  (N_CH),
      .W_W   (W_W),
      .ACC_W (ACC_W),
      .THRESH(THRESH)
    ) u_neuron (
      .x_i    (x_q),
      .row_i  (rows_q[i]),
      .acc_o  (acc[i]),
      .spike_o(spike[i]),
      .row_o  (rows_d[i])
    );
    assign x_d[i*ACC_W +: ACC_W] = spike[i] ? acc[i] : '0;
  end

  always_comb begin
    idx_d = '0;
    best  = x_q[0 +: ACC_W];
    for (int i = 1; i < N_CH; i++) begin
      if (x_q[i*ACC_W +: ACC_W] > best) begin
        best  = x_q[i*ACC_W +: ACC_W];
        idx_d = IW'(i);
      end
    end
  end

  function automatic logic [AW-1:0] row_addr(input logic [LW-1:0] layer, input int r);
    return AW'(int'(layer) * N_CH + r);
  endfunction

  // NOTE: the row buffer is reset along with the datapath; it is small and must read as zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      layer_q <= '0;
      cnt_q   <= '0;
      learn_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      x_q     <= '0;
      pred_q  <= '0;
      idx_q   <= '0;
      rows_q  <= '0;
    end else if (hold) begin
      state_q <= S_IDLE;
      layer_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            x_q     <= in_data;
            learn_q <= learn_en;
            busy_q  <= 1'b1;
            layer_q <= '0;
            cnt_q   <= '0;
            rd_q    <= 1'b1;
            addr_q  <= row_addr('0, 0);
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          // Row r is returned one cycle after its read, i.e. while cnt_q == r+1.
          for (int r = 0; r < N_CH; r++)
            if (int'(cnt_q) == r + 1) rows_q[r] <= mem_rdata;
          if (int'(cnt_q) + 1 < N_CH) begin
            rd_q   <= 1'b1;
            addr_q <= row_addr(layer_q, int'(cnt_q) + 1);
          end else begin
            rd_q <= 1'b0;
          end
          if (int'(cnt_q) == N_CH) begin
            cnt_q   <= '0;
            state_q <= S_COMPUTE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_COMPUTE: begin
          x_q <= x_d;
          if (learn_q) begin
            rows_q  <= rows_d;
            wr_q    <= 1'b1;
            addr_q  <= row_addr(layer_q, 0);
            wdata_q <= rows_d[0];
            cnt_q   <= '0;
            state_q <= S_UPDATE;
          end else begin
            state_q <= S_NEXT;
          end
        end
        S_UPDATE: begin
          if (int'(cnt_q) + 1 < N_CH) begin
            for (int r = 0; r < N_CH; r++)
              if (int'(cnt_q) + 1 == r) wdata_q <= rows_q[r];
            addr_q <= row_addr(layer_q, int'(cnt_q) + 1);
            cnt_q  <= cnt_q + 1'b1;
          end else begin
            wr_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (layer_q == LW'(LAYERS - 1)) begin
            pred_q  <= x_q;
            idx_q   <= idx_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_FIN;
          end else begin
            layer_q <= layer_q + 1'b1;
            cnt_q   <= '0;
            rd_q    <= 1'b1;
            addr_q  <= row_addr(layer_q + 1'b1, 0);
            state_q <= S_LOAD;
          end
        end
        S_FIN: begin
          layer_q <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Strobes are masked by hold in the same cycle so the host owns the RAM the moment it asks.
  assign mem_rd_en = rd_q & ~hold;
  assign mem_wr_en = wr_q & ~hold;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pred      = pred_q;
  assign pred_idx  = idx_q;

endmodule

// File: tb/tb_snn_layer_engine.sv
// Bench for snn_layer_engine (N_CH=2, LAYERS=2): table-driven runs with read/write/result scoreboards,
// plus hand sequences for hold during write-back and reset during load.
module tb_snn_layer_engine;

  localparam int N_CH = 2, W_W = 4, ACC_W = 8, LAYERS = 2, THRESH = 1, AW = 2, ROWS = 4;

  logic                  clk = 1'b0;
  logic                  rst, start, learn_en, hold;
  logic [N_CH*ACC_W-1:0] in_data;
  logic                  busy, done, mem_rd_en, mem_wr_en;
  logic [AW-1:0]         mem_addr;
  logic [N_CH*W_W-1:0]   mem_rdata, mem_wdata;
  logic [N_CH*ACC_W-1:0] pred;
  logic                  pred_idx;

  logic [7:0] mem [ROWS];

  snn_layer_engine #(
    .N_CH(N_CH), .W_W(W_W), .ACC_W(ACC_W), .LAYERS(LAYERS), .THRESH(THRESH), .AW(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .learn_en(learn_en), .hold(hold), .in_data(in_data),
    .busy(busy), .done(done), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata), .pred(pred), .pred_idx(pred_idx)
  );

  always #5 clk = ~clk;

  // Weight RAM model: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [15:0] pred;
    logic        idx;
  } res_t;

  logic [31:0] rd_exp[$];
  logic [31:0] wr_exp[$];
  res_t        res_exp[$];
  logic [31:0] mon_e;
  res_t        mon_r;

  // Scoreboard: every strobe and every done is matched against what the stimulus queued.
  always @(negedge clk) begin
    if (mem_rd_en || mem_wr_en)
      check("rd_wr_exclusive", 32'({mem_rd_en, mem_wr_en} == 2'b11), 32'd0);
    if (mem_rd_en) begin
      mon_e = (rd_exp.size() != 0) ? rd_exp.pop_front() : 32'hFFFF_FFFF;
      check("rd_addr", 32'(mem_addr), mon_e);
    end
    if (mem_wr_en) begin
      mon_e = (wr_exp.size() != 0) ? wr_exp.pop_front() : 32'hFFFF_FFFF;
      check("wr_addr_data", {22'd0, mem_addr, mem_wdata}, mon_e);
    end
    if (done) begin
      if (res_exp.size() != 0) begin
        mon_r = res_exp.pop_front();
        check("pred", 32'(pred), 32'(mon_r.pred));
        check("pred_idx", 32'(pred_idx), 32'(mon_r.idx));
      end else begin
        check("unexpected_done", 32'(pred), 32'hFFFF_FFFF);
      end
    end
  end

  typedef struct {
    logic [7:0]  x0, x1;
    logic [31:0] w;      // {row3,row2,row1,row0}; row = {w[i][1], w[i][0]}
    logic        learn;
    logic [7:0]  p0, p1;
    logic        idx;
    logic [31:0] wout;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input vec_t v, input string tag);
    int n;
    for (int r = 0; r < ROWS; r++) begin
      mem[r] = v.w[r*8 +: 8];
      rd_exp.push_back(32'(r));
      if (v.learn) wr_exp.push_back({22'd0, 2'(r), v.wout[r*8 +: 8]});
    end
    res_exp.push_back('{pred: {v.p1, v.p0}, idx: v.idx});
    @(negedge clk);
    in_data  = {v.x1, v.x0};
    learn_en = v.learn;
    start    = 1'b1;
    @(posedge clk);
    n = 1;
    #1;
    start    = 1'b0;
    in_data  = 16'hA5A5;
    learn_en = ~v.learn;
    while (n < 60) begin
      @(negedge clk);
      if (done) break;
      start = (n == 3);  // a start while busy must be ignored
      @(posedge clk);
      n++;
    end
    start = 1'b0;
    check({tag, "_done_cycle"}, 32'(n), v.learn ? 32'd15 : 32'd11);
    @(posedge clk);
    #1;
    check({tag, "_done_single"}, 32'({done, busy}), 32'd0);
    check({tag, "_queues_empty"}, 32'(rd_exp.size() + wr_exp.size() + res_exp.size()), 32'd0);
    check({tag, "_mem_final"}, {mem[3], mem[2], mem[1], mem[0]}, v.wout);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //              x0      x1      w             learn p0       p1       idx   wout
    vecs[0] = '{8'd3,   8'd2,   32'h0000_0000, 1'b0, 8'd10,  8'd10,  1'b0, 32'h0000_0000};
    vecs[1] = '{8'd3,   8'd2,   32'h0000_0000, 1'b1, 8'd10,  8'd10,  1'b0, 32'h1111_1111};
    vecs[2] = '{8'd200, 8'd0,   32'h7777_7777, 1'b1, 8'd255, 8'd255, 1'b0, 32'h7777_7777};
    vecs[3] = '{8'd2,   8'd0,   32'h8888_8888, 1'b1, 8'd0,   8'd0,   1'b0, 32'h8888_8888};
    vecs[4] = '{8'd4,   8'd6,   32'h1F00_01F0, 1'b1, 8'd21,  8'd31,  1'b1, 32'h2011_1201};
    vecs[5] = '{8'd1,   8'd0,   32'h0000_0000, 1'b0, 8'd0,   8'd0,   1'b0, 32'h0000_0000};
    vecs[6] = '{8'd255, 8'd255, 32'h0000_0000, 1'b0, 8'd255, 8'd255, 1'b0, 32'h0000_0000};
    vecs[7] = '{8'd2,   8'd3,   32'h0000_1001, 1'b0, 8'd15,  8'd15,  1'b0, 32'h0000_1001};

    rst = 1'b1; start = 1'b0; learn_en = 1'b0; hold = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {busy, done, mem_rd_en, mem_wr_en, mem_addr, mem_wdata}, 32'd0);
    check("reset_pred", {15'd0, pred, pred_idx}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // hold raised in the second write-back cycle of layer 0
    for (int r = 0; r < ROWS; r++) mem[r] = 8'h00;
    rd_exp.push_back(32'd0);
    rd_exp.push_back(32'd1);
    wr_exp.push_back({22'd0, 2'd0, 8'h11});
    @(negedge clk);
    in_data = {8'd2, 8'd3}; learn_en = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (mem_wr_en) break;
    end
    check("hold_first_write", 32'(mem_wr_en), 32'd1);
    @(posedge clk);
    #1 hold = 1'b1;
    @(negedge clk);
    check("hold_strobes_masked", 32'({mem_rd_en, mem_wr_en}), 32'd0);
    @(posedge clk);
    #1;
    check("hold_idle", 32'({busy, done}), 32'd0);
    hold = 1'b0;
    repeat (4) @(negedge clk);
    check("hold_busy_stays_low", 32'(busy), 32'd0);
    check("hold_rows", {mem[1], mem[0]}, 32'h0000_0011);
    check("hold_pred_kept", 32'(pred), 32'h0000_0F0F);
    check("hold_queues_empty", 32'(rd_exp.size() + wr_exp.size() + res_exp.size()), 32'd0);
    run_vec(vecs[1], "after_hold");

    // asynchronous reset during LOAD
    for (int r = 0; r < ROWS; r++) mem[r] = 8'h00;
    rd_exp.push_back(32'd0);
    rd_exp.push_back(32'd1);
    @(negedge clk);
    in_data = {8'd2, 8'd3}; learn_en = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_outputs", {busy, done, mem_rd_en, mem_wr_en, mem_addr, mem_wdata}, 32'd0);
    check("rst_pred", {15'd0, pred, pred_idx}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_reads_done", 32'(rd_exp.size()), 32'd0);
    run_vec(vecs[4], "after_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
